// File: rtl/evg_pkg.sv
// rtl/evg_pkg.sv - shared EVG constants and width helper
package evg_pkg;

    localparam int EVENTCODE_WIDTH = 8;

    localparam logic [7:0] EVG_NULL_EVENT_CODE     = 8'h00;
    localparam logic [7:0] END_OF_TABLE_EVENT_CODE = 8'h7F;

    // Width of an index into n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/evg_event_arbiter_if.sv
// rtl/evg_event_arbiter_if.sv - request inputs and event output stream of the EVG event arbiter
interface evg_event_arbiter_if #(
    parameter int NUM_REQUESTERS  = 4,
    parameter int EVENTCODE_WIDTH = evg_pkg::EVENTCODE_WIDTH,
    parameter int USER_WIDTH      = evg_pkg::clog2_min1(NUM_REQUESTERS)
);

    logic [NUM_REQUESTERS*EVENTCODE_WIDTH-1:0] reqTDATA;
    logic [NUM_REQUESTERS-1:0]                 reqTVALID;

    logic [EVENTCODE_WIDTH-1:0] evgEventTDATA;
    logic [USER_WIDTH-1:0]      evgEventTUSER;
    logic                       evgEventTVALID;
    logic                       evgEventTREADY;

    // Environment side: event sources plus the transmitter's ready.
    modport master (
        output reqTDATA, reqTVALID, evgEventTREADY,
        input  evgEventTDATA, evgEventTUSER, evgEventTVALID
    );

    // Arbiter side.
    modport slave (
        input  reqTDATA, reqTVALID, evgEventTREADY,
        output evgEventTDATA, evgEventTUSER, evgEventTVALID
    );

endinterface

// File: rtl/evg_event_arb_fifo.sv
// rtl/evg_event_arb_fifo.sv - per-source event FIFO, register array with wrap-bit pointers
module evg_event_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_rd,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; contents are only observed while non-empty.
    always_ff @(posedge i_clk) begin
        if (i_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    // A write into a full FIFO lands in the slot being read out this cycle, which
    // the consumer has already captured from the combinational head.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/evg_event_arbiter.sv
// rtl/evg_event_arbiter.sv - merges per-source event FIFOs into one stream; EVG_ARB_ROUND_ROBIN_EN selects round-robin grant
module evg_event_arbiter
    import evg_pkg::*;
#(
    parameter int NUM_REQUESTERS     = 4,
    parameter int EVENTCODE_WIDTH    = evg_pkg::EVENTCODE_WIDTH,
    parameter int FIFO_DEPTH         = 4,
    parameter int DROP_COUNTER_WIDTH = 8
) (
    input  logic                                         evgTxClk,
    input  logic                                         evgTxReset,
    evg_event_arbiter_if.slave                           bus,
    input  logic                                         dropCountClear,
    output logic [NUM_REQUESTERS*DROP_COUNTER_WIDTH-1:0] dropCount
);

    localparam int W   = EVENTCODE_WIDTH;
    localparam int UW  = clog2_min1(NUM_REQUESTERS);
    localparam int DCW = DROP_COUNTER_WIDTH;

    logic [W-1:0]              w_req_code [NUM_REQUESTERS];
    logic [W-1:0]              w_dout     [NUM_REQUESTERS];
    logic [NUM_REQUESTERS-1:0] w_req_live;
    logic [NUM_REQUESTERS-1:0] w_full;
    logic [NUM_REQUESTERS-1:0] w_empty;
    logic [NUM_REQUESTERS-1:0] w_wr;
    logic [NUM_REQUESTERS-1:0] w_pop;
    logic [NUM_REQUESTERS-1:0] w_drop;

    logic          w_grant_found;
    logic [UW-1:0] w_grant_idx;
    logic          w_load;

    logic          r_valid;
    logic [W-1:0]  r_data;
    logic [UW-1:0] r_user;

    genvar g;
    generate
        for (g = 0; g < NUM_REQUESTERS; g++) begin : g_src
            logic [DCW-1:0] r_drop_cnt;

            assign w_req_code[g] = bus.reqTDATA[g*W +: W];
            assign w_req_live[g] = bus.reqTVALID[g] && (w_req_code[g] != W'(EVG_NULL_EVENT_CODE));
            assign w_pop[g]      = w_load && (w_grant_idx == UW'(g));
            assign w_wr[g]       = w_req_live[g] && (!w_full[g] || w_pop[g]);
            assign w_drop[g]     = w_req_live[g] && w_full[g] && !w_pop[g];

            evg_event_arb_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (W)
            ) u_fifo (
                .i_clk   (evgTxClk),
                .i_rst   (evgTxReset),
                .i_wr    (w_wr[g]),
                .i_din   (w_req_code[g]),
                .i_rd    (w_pop[g]),
                .o_full  (w_full[g]),
                .o_empty (w_empty[g]),
                .o_dout  (w_dout[g])
            );

            // Saturating drop counter; a clear wins but the same cycle's drop still counts.
            always_ff @(posedge evgTxClk or posedge evgTxReset) begin
                if (evgTxReset) begin
                    r_drop_cnt <= '0;
                end else if (dropCountClear) begin
                    r_drop_cnt <= w_drop[g] ? DCW'(1) : '0;
                end else if (w_drop[g] && (r_drop_cnt != {DCW{1'b1}})) begin
                    r_drop_cnt <= r_drop_cnt + DCW'(1);
                end
            end

            assign dropCount[g*DCW +: DCW] = r_drop_cnt;
        end
    endgenerate

`ifdef EVG_ARB_ROUND_ROBIN_EN
    logic [UW-1:0] r_rr_ptr;

    // Round-robin: first non-empty FIFO above the last grant, else wrap to the lowest.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (!w_grant_found && !w_empty[k] && (UW'(k) > r_rr_ptr)) begin
                w_grant_found = 1'b1;
                w_grant_idx   = UW'(k);
            end
        end
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (!w_grant_found && !w_empty[k]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = UW'(k);
            end
        end
    end

    // Pointer follows the source that actually loaded the output stage.
    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            r_rr_ptr <= UW'(NUM_REQUESTERS - 1);
        end else if (w_load) begin
            r_rr_ptr <= w_grant_idx;
        end
    end
`else
    // Fixed priority: lowest-index non-empty FIFO wins.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            if (!w_grant_found && !w_empty[k]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = UW'(k);
            end
        end
    end
`endif

    assign w_load = (!r_valid || bus.evgEventTREADY) && w_grant_found;

    // Single output register; holds data and source index while back-pressured.
    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_dout[w_grant_idx];
            r_user  <= w_grant_idx;
        end else if (bus.evgEventTREADY) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.evgEventTVALID = r_valid;
    assign bus.evgEventTDATA  = r_data;
    assign bus.evgEventTUSER  = r_user;

endmodule

// File: tb/tb_evg_event_arbiter.sv
// tb/tb_evg_event_arbiter.sv - directed bench for evg_event_arbiter; expectations follow EVG_ARB_ROUND_ROBIN_EN
module tb_evg_event_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drop_clear = 1'b0;
    logic [31:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    evg_event_arbiter_if #(.NUM_REQUESTERS(4), .EVENTCODE_WIDTH(8)) bus ();

    evg_event_arbiter #(
        .NUM_REQUESTERS     (4),
        .EVENTCODE_WIDTH    (8),
        .FIFO_DEPTH         (4),
        .DROP_COUNTER_WIDTH (8)
    ) dut (
        .evgTxClk       (clk),
        .evgTxReset     (rst),
        .bus            (bus),
        .dropCountClear (drop_clear),
        .dropCount      (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int src, input logic [7:0] code);
        bus.reqTVALID[src]       = 1'b1;
        bus.reqTDATA[src*8 +: 8] = code;
    endtask

    task automatic idle_req();
        bus.reqTVALID = '0;
        bus.reqTDATA  = '0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] u);
        check({tag, ".valid"}, 32'(bus.evgEventTVALID), 32'(v));
        if (v) begin
            check({tag, ".data"}, 32'(bus.evgEventTDATA), 32'(d));
            check({tag, ".user"}, 32'(bus.evgEventTUSER), 32'(u));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        idle_req();
        bus.evgEventTREADY = 1'b0;
        do_reset();
        step();
        check_out("reset", 1'b0, 8'h00, 2'd0);
        check("reset.data", 32'(bus.evgEventTDATA), 32'h0);
        check("reset.user", 32'(bus.evgEventTUSER), 32'h0);
        check("reset.drop", drop_count, 32'h0);

        // 1: single event, two-cycle latency
        bus.evgEventTREADY = 1'b1;
        set_req(0, 8'h11);
        check_out("t1.c0", 1'b0, 8'h00, 2'd0);
        step();
        idle_req();
        check_out("t1.c1", 1'b0, 8'h00, 2'd0);
        step();
        check_out("t1.c2", 1'b1, 8'h11, 2'd0);
        step();
        check_out("t1.c3", 1'b0, 8'h00, 2'd0);

        // 2: simultaneous requests from sources 0 and 2
        do_reset();
        bus.evgEventTREADY = 1'b1;
        set_req(0, 8'h21);
        set_req(2, 8'h23);
        step();
        idle_req();
        check_out("t2.c1", 1'b0, 8'h00, 2'd0);
        step();
        check_out("t2.c2", 1'b1, 8'h21, 2'd0);
        step();
        check_out("t2.c3", 1'b1, 8'h23, 2'd2);
        step();
        check_out("t2.c4", 1'b0, 8'h00, 2'd0);

        // 2b: grant to source 0, then sources 1 and 0 together
        set_req(0, 8'h10);
        step();
        idle_req();
        step();
        check_out("t2b.prior", 1'b1, 8'h10, 2'd0);
        step();
        set_req(1, 8'h22);
        set_req(0, 8'h21);
        step();
        idle_req();
        step();
`ifdef EVG_ARB_ROUND_ROBIN_EN
        check_out("t2b.first", 1'b1, 8'h22, 2'd1);
        step();
        check_out("t2b.second", 1'b1, 8'h21, 2'd0);
`else
        check_out("t2b.first", 1'b1, 8'h21, 2'd0);
        step();
        check_out("t2b.second", 1'b1, 8'h22, 2'd1);
`endif
        step();
        check_out("t2b.idle", 1'b0, 8'h00, 2'd0);

        // 3: back-pressure, fill, one drop, then drain in order
        bus.evgEventTREADY = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_req(1, 8'h31 + 8'(k));
            step();
        end
        idle_req();
        check("t3.drop", drop_count, 32'h0000_0100);
        for (int k = 0; k < 3; k++) begin
            check_out("t3.hold", 1'b1, 8'h31, 2'd1);
            step();
        end
        bus.evgEventTREADY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_out("t3.drain", 1'b1, 8'h31 + 8'(k), 2'd1);
            step();
        end
        check_out("t3.empty", 1'b0, 8'h00, 2'd0);

        // 4: null event code is ignored
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            set_req(3, 8'h00);
            step();
            seen += int'(bus.evgEventTVALID);
        end
        idle_req();
        for (int k = 0; k < 3; k++) begin
            step();
            seen += int'(bus.evgEventTVALID);
        end
        check("t4.no_output", 32'(seen), 32'h0);
        check("t4.drop", drop_count, 32'h0000_0100);

        // 5: saturation of the source-2 counter, then clear with a coincident drop
        bus.evgEventTREADY = 1'b0;
        for (int k = 0; k < 305; k++) begin
            set_req(2, 8'h50);
            step();
            if (k == 14)  check("t5.cnt10", 32'(drop_count[23:16]), 32'd10);
            if (k == 258) check("t5.cnt254", 32'(drop_count[23:16]), 32'd254);
            if (k == 259) check("t5.cnt255", 32'(drop_count[23:16]), 32'd255);
        end
        idle_req();
        check("t5.sat", drop_count, 32'h00FF_0100);
        check_out("t5.hold", 1'b1, 8'h50, 2'd2);
        set_req(2, 8'h51);
        drop_clear = 1'b1;
        step();
        drop_clear = 1'b0;
        idle_req();
        check("t5.clear_drop", drop_count, 32'h0001_0000);

        // 6: reset while back-pressured with queued events
        #2;
        rst = 1'b1;
        #1;
        check("t6.async_valid", 32'(bus.evgEventTVALID), 32'h0);
        check("t6.async_data", 32'(bus.evgEventTDATA), 32'h0);
        step();
        step();
        rst = 1'b0;
        bus.evgEventTREADY = 1'b1;
        check("t6.drop", drop_count, 32'h0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            seen += int'(bus.evgEventTVALID);
        end
        check("t6.no_stale", 32'(seen), 32'h0);
        set_req(0, 8'h44);
        step();
        idle_req();
        check_out("t6.c1", 1'b0, 8'h00, 2'd0);
        step();
        check_out("t6.c2", 1'b1, 8'h44, 2'd0);
        step();
        check_out("t6.c3", 1'b0, 8'h00, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
